// File: rtl/hard_mem_1rw_bit_mask_d64_w15_arbiter_if.sv
// Bus bundle between the two client pipelines, the arbiter and the memory
// wrapper. Signal names carry the arbiter's point of view (_i into it, _o out).
interface hard_mem_1rw_bit_mask_d64_w15_arbiter_if #(
    parameter int width_p = 15,
    parameter int els_p   = 64
);
    localparam int addr_width_lp = $clog2(els_p);

    // Requester side
    logic [1:0]                   req_v_i;
    logic [1:0]                   req_w_i;
    logic [2*addr_width_lp-1:0]   req_addr_i;
    logic [2*width_p-1:0]         req_data_i;
    logic [2*width_p-1:0]         req_w_mask_i;
    logic [1:0]                   req_ready_o;
    logic [1:0]                   resp_v_o;
    logic [width_p-1:0]           resp_data_o;
    logic                         init_done_o;

    // Memory side
    logic                         mem_v_o;
    logic                         mem_w_o;
    logic [addr_width_lp-1:0]     mem_addr_o;
    logic [width_p-1:0]           mem_data_o;
    logic [width_p-1:0]           mem_w_mask_o;
    logic [width_p-1:0]           mem_data_i;

    // The arbiter itself
    modport slave (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_w_mask_i, mem_data_i,
        output req_ready_o, resp_v_o, resp_data_o, init_done_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );

    // The surrounding environment (clients plus memory wrapper)
    modport master (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_w_mask_i, mem_data_i,
        input  req_ready_o, resp_v_o, resp_data_o, init_done_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );
endinterface

// File: rtl/hard_mem_1rw_bit_mask_d64_w15_arbiter.sv
// Two-requester round-robin front end for a 64x15 single-port bit-masked
// memory. Zero-fills the array after reset, then forwards the winning request
// to the memory port with zero latency and returns read data, tagged one-hot,
// one cycle after the grant (the memory has a one-cycle synchronous read).
module hard_mem_1rw_bit_mask_d64_w15_arbiter #(
    parameter int width_p          = 15,
    parameter int els_p            = 64,
    parameter int clear_on_reset_p = 1
) (
    input logic clk_i,
    input logic reset_n_i,
    hard_mem_1rw_bit_mask_d64_w15_arbiter_if.slave bus
);
    localparam int addr_width_lp = $clog2(els_p);
    // One spare bit so the fill counter can step past the last entry without wrapping
    localparam int cnt_width_lp  = addr_width_lp + 1;
    localparam logic [cnt_width_lp-1:0] init_last_lp = cnt_width_lp'(els_p - 1);

    typedef enum logic [0:0] {
        INIT_S = 1'b0,
        RUN_S  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [cnt_width_lp-1:0]   init_cnt_q, init_cnt_d;
    logic                      last_q, last_d;      // index of the last requester granted
    logic [1:0]                pend_q, pend_d;      // one-hot read response due next cycle

    logic                      in_init;
    logic                      in_run;
    logic [1:0]                grant;
    logic                      win;

    logic                      win_w;
    logic [addr_width_lp-1:0]  win_addr;
    logic [width_p-1:0]        win_data;
    logic [width_p-1:0]        win_mask;

    // Outputs are qualified with the reset pin so everything stays quiet while
    // reset is held, including the clear_on_reset_p=0 case where the state
    // register resets straight into RUN.
    assign in_init = reset_n_i & (state_q == INIT_S);
    assign in_run  = reset_n_i & (state_q == RUN_S);

    // Round-robin pick: a lone requester wins, on contention the one not granted last wins
    always_comb begin
        grant = 2'b00;
        win   = 1'b0;
        case (bus.req_v_i)
            2'b01: grant = 2'b01;
            2'b10: begin
                grant = 2'b10;
                win   = 1'b1;
            end
            2'b11: begin
                if (last_q) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                    win   = 1'b1;
                end
            end
            default: begin
                grant = 2'b00;
                win   = 1'b0;
            end
        endcase
    end

    // Extract the winning requester's command fields from the packed request buses
    always_comb begin
        win_w    = bus.req_w_i[win];
        win_addr = bus.req_addr_i[int'(win)*addr_width_lp +: addr_width_lp];
        win_data = bus.req_data_i[int'(win)*width_p +: width_p];
        win_mask = bus.req_w_mask_i[int'(win)*width_p +: width_p];
    end

    // Memory port mux: zero-fill writes during INIT, the granted request during RUN
    always_comb begin
        bus.mem_v_o      = 1'b0;
        bus.mem_w_o      = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        bus.mem_w_mask_o = '0;
        if (in_init) begin
            bus.mem_v_o      = 1'b1;
            bus.mem_w_o      = 1'b1;
            bus.mem_addr_o   = init_cnt_q[addr_width_lp-1:0];
            bus.mem_data_o   = '0;
            bus.mem_w_mask_o = '1;
        end else if (in_run && (grant != 2'b00)) begin
            bus.mem_v_o      = 1'b1;
            bus.mem_w_o      = win_w;
            bus.mem_addr_o   = win_addr;
            bus.mem_data_o   = win_data;
            bus.mem_w_mask_o = win_mask;
        end
    end

    // Next-state: fill counter and INIT->RUN hand-over, grant pointer and read-pending tag
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_d     = last_q;
        pend_d     = 2'b00;
        case (state_q)
            INIT_S: begin
                init_cnt_d = init_cnt_q + cnt_width_lp'(1);
                if (init_cnt_q == init_last_lp) begin
                    state_d = RUN_S;
                end
            end
            RUN_S: begin
                if (grant != 2'b00) begin
                    last_d = win;
                    if (!win_w) begin
                        pend_d = grant;
                    end
                end
            end
            default: begin
                state_d = INIT_S;
            end
        endcase
    end

    // Control state; pointer resets to requester 1 so requester 0 wins the first contention
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= (clear_on_reset_p != 0) ? INIT_S : RUN_S;
            init_cnt_q <= '0;
            last_q     <= 1'b1;
            pend_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.req_ready_o = in_run ? grant : 2'b00;
    assign bus.init_done_o = in_run;
    // The pending register is cleared asynchronously, so a reset kills the response at once
    assign bus.resp_v_o    = pend_q;
    // Read data is a straight pass-through of the memory's registered output
    assign bus.resp_data_o = bus.mem_data_i;

endmodule

// File: tb/tb_hard_mem_1rw_bit_mask_d64_w15_arbiter.sv
// Testbench for the two-requester memory arbiter: a bit-masked synchronous
// memory model sits on the memory port, a reference model of the arbiter's
// contract is checked every cycle, and directed scenarios pin literal values.
module tb_hard_mem_1rw_bit_mask_d64_w15_arbiter;
    localparam int W  = 15;
    localparam int D  = 64;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hard_mem_1rw_bit_mask_d64_w15_arbiter_if #(.width_p(W), .els_p(D)) bus ();

    hard_mem_1rw_bit_mask_d64_w15_arbiter #(
        .width_p(W), .els_p(D), .clear_on_reset_p(1)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory wrapper model (synchronous read, bit-masked write)
    logic [W-1:0] mem [D];
    logic [W-1:0] mem_rdata = '0;
    bit           seeded    = 1'b0;
    assign bus.mem_data_i = mem_rdata;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < D; i++) mem[i] <= W'($urandom);
            seeded <= 1'b1;
        end else if (bus.mem_v_o) begin
            if (bus.mem_w_o)
                mem[bus.mem_addr_o] <= (mem[bus.mem_addr_o] & ~bus.mem_w_mask_o)
                                       | (bus.mem_data_o & bus.mem_w_mask_o);
            else
                mem_rdata <= mem[bus.mem_addr_o];
        end
    end

    // ---------------- reference model, checked mid-cycle on every cycle
    bit           m_init = 1'b1;
    int           m_cnt  = 0;
    int           m_ptr  = 1;
    int           m_pend = 0;
    int           m_pend_data = 0;
    logic [W-1:0] ref_mem [D];
    int           v, win, a, d, mk, exp_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 32'(bus.req_ready_o), 0);
            chk("rst_resp_v", 32'(bus.resp_v_o), 0);
            chk("rst_init_done", 32'(bus.init_done_o), 0);
            chk("rst_mem_v", 32'(bus.mem_v_o), 0);
            m_init = 1'b1;
            m_cnt  = 0;
            m_ptr  = 1;
            m_pend = 0;
        end else if (m_init) begin
            chk("init_ready", 32'(bus.req_ready_o), 0);
            chk("init_resp_v", 32'(bus.resp_v_o), 0);
            chk("init_done_low", 32'(bus.init_done_o), 0);
            chk("init_mem_v", 32'(bus.mem_v_o), 1);
            chk("init_mem_w", 32'(bus.mem_w_o), 1);
            chk("init_mem_addr", 32'(bus.mem_addr_o), m_cnt);
            chk("init_mem_data", 32'(bus.mem_data_o), 0);
            chk("init_mem_mask", 32'(bus.mem_w_mask_o), 'h7FFF);
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) m_init = 1'b0;
        end else begin
            chk("run_init_done", 32'(bus.init_done_o), 1);
            chk("run_resp_v", 32'(bus.resp_v_o), m_pend);
            if (m_pend != 0) chk("run_resp_data", 32'(bus.resp_data_o), m_pend_data);
            v = int'(bus.req_v_i);
            if (v == 0)      win = -1;
            else if (v == 1) win = 0;
            else if (v == 2) win = 1;
            else             win = (m_ptr == 0) ? 1 : 0;
            exp_rdy = (win < 0) ? 0 : (1 << win);
            chk("run_ready", 32'(bus.req_ready_o), exp_rdy);
            chk("run_mem_v", 32'(bus.mem_v_o), (win >= 0) ? 1 : 0);
            if (win >= 0) begin
                a  = int'(bus.req_addr_i[win*AW +: AW]);
                d  = int'(bus.req_data_i[win*W +: W]);
                mk = int'(bus.req_w_mask_i[win*W +: W]);
                chk("run_mem_w", 32'(bus.mem_w_o), 32'(bus.req_w_i[win]));
                chk("run_mem_addr", 32'(bus.mem_addr_o), a);
                if (bus.req_w_i[win]) begin
                    chk("run_mem_data", 32'(bus.mem_data_o), d);
                    chk("run_mem_mask", 32'(bus.mem_w_mask_o), mk);
                    ref_mem[a] = W'((int'(ref_mem[a]) & ~mk) | (d & mk));
                    m_pend = 0;
                end else begin
                    m_pend      = 1 << win;
                    m_pend_data = int'(ref_mem[a]);
                end
                m_ptr = win;
            end else begin
                chk("idle_mem_w", 32'(bus.mem_w_o), 0);
                chk("idle_mem_addr", 32'(bus.mem_addr_o), 0);
                chk("idle_mem_data", 32'(bus.mem_data_o), 0);
                chk("idle_mem_mask", 32'(bus.mem_w_mask_o), 0);
                m_pend = 0;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic req(input logic [1:0] rv, input logic [1:0] rw,
                       input int a0, input int a1, input int d0, input int d1,
                       input int k0, input int k1);
        bus.req_v_i      = rv;
        bus.req_w_i      = rw;
        bus.req_addr_i   = {AW'(a1), AW'(a0)};
        bus.req_data_i   = {W'(d1), W'(d0)};
        bus.req_w_mask_i = {W'(k1), W'(k0)};
    endtask

    task automatic idle();
        req(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1);
    end

    // ---------------- directed scenarios
    initial begin
        // both requesters present reads while reset and INIT are in progress
        req(2'b11, 2'b00, 1, 2, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_ready", 32'(bus.req_ready_o), 0);
        chk("lit_rst_mem_v", 32'(bus.mem_v_o), 0);
        rst_n = 1'b1;
        #1;
        chk("lit_init_first_addr", 32'(bus.mem_addr_o), 0);
        chk("lit_init_first_v", 32'(bus.mem_v_o), 1);
        repeat (63) @(posedge clk);
        #2;
        chk("lit_init_last_addr", 32'(bus.mem_addr_o), 63);
        chk("lit_init_last_done", 32'(bus.init_done_o), 0);
        chk("lit_init_last_ready", 32'(bus.req_ready_o), 0);
        step();
        idle();
        #1;
        chk("lit_init_done", 32'(bus.init_done_o), 1);

        // r0 writes 0x1234 to addr 5, r1 reads it back
        step(); req(2'b01, 2'b01, 5, 0, 'h1234, 0, 'h7FFF, 0); #1;
        chk("lit_wr_ready", 32'(bus.req_ready_o), 1);
        step(); req(2'b10, 2'b00, 0, 5, 0, 0, 0, 0); #1;
        chk("lit_rd_ready", 32'(bus.req_ready_o), 2);
        chk("lit_rd_no_resp", 32'(bus.resp_v_o), 0);
        step(); idle(); #1;
        chk("lit_rd_resp_v", 32'(bus.resp_v_o), 2);
        chk("lit_rd_resp_data", 32'(bus.resp_data_o), 'h1234);

        // masked write of the low byte only
        step(); req(2'b01, 2'b01, 5, 0, 'h7FFF, 0, 'h00FF, 0);
        step(); req(2'b01, 2'b00, 5, 0, 0, 0, 0, 0); #1;
        chk("lit_mask_rd_ready", 32'(bus.req_ready_o), 1);
        step(); idle(); #1;
        chk("lit_mask_resp_v", 32'(bus.resp_v_o), 1);
        chk("lit_mask_resp_data", 32'(bus.resp_data_o), 'h12FF);

        // seed addr 1 and 2, then contend with reads for four cycles
        step(); req(2'b01, 2'b01, 1, 0, 'h0AAA, 0, 'h7FFF, 0);
        step(); req(2'b10, 2'b10, 0, 2, 0, 'h5555, 0, 'h7FFF);
        step(); req(2'b11, 2'b00, 1, 2, 0, 0, 0, 0); #1;
        chk("lit_rr_grant0", 32'(bus.req_ready_o), 1);
        for (int k = 1; k < 4; k++) begin
            step(); #1;
            chk("lit_rr_grant", 32'(bus.req_ready_o), (k % 2 == 1) ? 2 : 1);
            chk("lit_rr_resp_v", 32'(bus.resp_v_o), (k % 2 == 1) ? 1 : 2);
            chk("lit_rr_resp_data", 32'(bus.resp_data_o), (k % 2 == 1) ? 'h0AAA : 'h5555);
        end
        step(); idle(); #1;
        chk("lit_rr_last_resp_v", 32'(bus.resp_v_o), 2);
        chk("lit_rr_last_resp_data", 32'(bus.resp_data_o), 'h5555);

        // read then write to the same address on consecutive cycles
        step(); req(2'b01, 2'b00, 5, 0, 0, 0, 0, 0);
        step(); req(2'b10, 2'b10, 0, 5, 0, 0, 0, 'h7FFF); #1;
        chk("lit_hz_wr_ready", 32'(bus.req_ready_o), 2);
        chk("lit_hz_old_resp_v", 32'(bus.resp_v_o), 1);
        chk("lit_hz_old_data", 32'(bus.resp_data_o), 'h12FF);
        step(); req(2'b01, 2'b00, 5, 0, 0, 0, 0, 0);
        step(); idle(); #1;
        chk("lit_hz_new_resp_v", 32'(bus.resp_v_o), 1);
        chk("lit_hz_new_data", 32'(bus.resp_data_o), 0);

        // reset lands while a read response is on the bus
        step(); req(2'b01, 2'b01, 5, 0, 'h2A2A, 0, 'h7FFF, 0);
        step(); req(2'b10, 2'b00, 0, 5, 0, 0, 0, 0); #1;
        chk("lit_mr_rd_ready", 32'(bus.req_ready_o), 2);
        step(); idle(); #1;
        chk("lit_mr_resp_before", 32'(bus.resp_v_o), 2);
        chk("lit_mr_data_before", 32'(bus.resp_data_o), 'h2A2A);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_mr_resp_dropped", 32'(bus.resp_v_o), 0);
        chk("lit_mr_done_dropped", 32'(bus.init_done_o), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("lit_mr_init_addr0", 32'(bus.mem_addr_o), 0);
        chk("lit_mr_init_v", 32'(bus.mem_v_o), 1);
        repeat (64) @(posedge clk);
        #1;
        req(2'b01, 2'b00, 5, 0, 0, 0, 0, 0); #1;
        chk("lit_mr_done_again", 32'(bus.init_done_o), 1);
        chk("lit_mr_rd_ready2", 32'(bus.req_ready_o), 1);
        step(); idle(); #1;
        chk("lit_mr_cleared_v", 32'(bus.resp_v_o), 1);
        chk("lit_mr_cleared_data", 32'(bus.resp_data_o), 0);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hard_mem_1rw_bit_mask_d64_w15_arbiter.md
Name: hard_mem_1rw_bit_mask_d64_w15_arbiter

Overview:
- Two-requester controller sharing one 64x15 single-port, bit-masked, read/write memory.
- Zero-fills the memory after reset.
- Arbitrates requests round-robin and drives the memory port.
- Returns read data to the winning requester one cycle after grant, tagged one-hot.
- Sits between two client pipelines and the memory wrapper; the memory's own reset pin is not driven by this block.

Parameters:
- width_p, 15: data and mask width in bits.
- els_p, 64: number of memory entries.
- addr_width_lp, $clog2(els_p): address width (derived; do not override).
- clear_on_reset_p, 1: 1 = run the INIT zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  2  request valid, bit r = requester r.
- req_w_i  in  2  1 = write, 0 = read, per requester.
- req_addr_i  in  2*addr_width_lp  address; requester r at slice [r*addr_width_lp +: addr_width_lp].
- req_data_i  in  2*width_p  write data, sliced per requester.
- req_w_mask_i  in  2*width_p  per-bit write enable, sliced per requester.
- req_ready_o  out  2  grant; request r is accepted when req_v_i[r] & req_ready_o[r].
- resp_v_o  out  2  one-hot read-response valid.
- resp_data_o  out  width_p  read data.
- init_done_o  out  1  high once the block is in RUN.
- mem_v_o  out  1  memory port valid.
- mem_w_o  out  1  memory port write.
- mem_addr_o  out  addr_width_lp  memory port address.
- mem_data_o  out  width_p  memory port write data.
- mem_w_mask_o  out  width_p  memory port write mask.
- mem_data_i  in  width_p  memory read data.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - state = INIT if clear_on_reset_p, else RUN.
  - init counter = 0; last-grant pointer = 1, so requester 0 wins first.
  - Response pending register cleared.
  - Outputs while reset is asserted: req_ready_o=0, resp_v_o=0, init_done_o=0, mem_v_o=0.
- INIT:
  - Each cycle drives mem_v_o=1, mem_w_o=1, mem_addr_o=counter, mem_data_o=0, mem_w_mask_o=all ones; counter increments.
  - After the write of addr els_p-1, go to RUN. The counter does not wrap and is unused afterwards.
  - req_ready_o=0 throughout INIT.
- RUN: init_done_o=1.
- Arbitration (combinational):
  - Exactly one valid requester: that requester wins.
  - Both valid: the requester not equal to the last-grant pointer wins.
  - req_ready_o is one-hot for the winner, or 0 if neither is valid.
  - req_ready_o depends combinationally on req_v_i; requesters must not derive req_v_i from req_ready_o.
  - The pointer updates to the winner on every grant and holds when idle.
- Memory drive in RUN:
  - mem_v_o = |req_v_i.
  - mem_w_o, mem_addr_o, mem_data_o and mem_w_mask_o are taken from the winner's slices in the same cycle (zero latency).
  - When mem_v_o=0 the other memory fields are don't-care; drive 0.
- Read response:
  - A granted read sets pending[r] at the clock edge.
  - Next cycle: resp_v_o = pending (one-hot) and resp_data_o = mem_data_i, combinational pass-through.
  - Valid for exactly one cycle; there is no response backpressure.
  - Back-to-back reads give back-to-back responses, throughput 1/cycle.
  - Writes produce no response.
- Hazards:
  - A write granted in the cycle a read response is presented does not affect that response; the memory updates at the end of that cycle, so the old value is returned.
  - A read granted in the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - resp_v_o drops immediately and the pending response is lost.
  - An in-progress INIT restarts at addr 0.
  - Accepted writes that completed before reset are overwritten by the new INIT.
- resp_data_o is don't-care when resp_v_o=0.

Test Plan:
- Release reset_n_i with clear_on_reset_p=1 -> 64 consecutive cycles of mem_v_o=1, mem_w_o=1, addr 0..63, mask 0x7FFF, data 0; init_done_o rises on cycle 65; req_ready_o=0 throughout even with req_v_i=2'b11.
- Write from r0 to addr 5, data 0x1234, mask 0x7FFF; next cycle r1 reads addr 5 -> req_ready_o=2'b10 on the read; the following cycle resp_v_o=2'b10 with resp_data_o=0x1234.
- Write addr 5, data 0x7FFF, mask 0x00FF; then read addr 5 -> resp_data_o=0x12FF.
- Both requesters hold reads of addr 1 and addr 2 for 4 cycles after init -> grants 01,10,01,10; responses alternate with the matching data, each one cycle after its grant.
- Read addr 5 (contents 0x12FF) granted in cycle N; in cycle N+1 write addr 5 with data 0 -> response in N+1 shows 0x12FF; a read in N+2 returns 0x0000.
- Pull reset_n_i low mid-cycle right after a read grant -> resp_v_o goes 0 asynchronously; after release INIT restarts at addr 0; a later read of addr 5 returns 0x0000.
